// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared defaults, requester/FSM types and address helper for mem_port_arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef enum logic {REQ_IF = 1'b0, REQ_D = 1'b1} req_id_e;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;
  typedef struct packed {
    req_id_e id;
    logic    we;
    logic    mis;
  } txn_t;
  function automatic logic [ADDR_W_DEF-1:0] byte_to_word(input logic [ADDR_W_DEF-1:0] a);
    return a >> 2;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline request/response and memory-side signals of the arbiter
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb_lat_tracker.sv
// mem_arb_lat_tracker: holds the single outstanding access and pulses done when its data is due
module mem_arb_lat_tracker import mem_arb_pkg::*; #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  txn_t txn_i,
  output logic done_o,
  output txn_t txn_o
);
  logic [2:0] cnt_q, cnt_d;
  txn_t       txn_q, txn_d;
  always_comb begin
    cnt_d = load_i ? 3'(MEM_LAT) : (cnt_q != 3'd0 ? cnt_q - 3'd1 : cnt_q);
    txn_d = load_i ? txn_i : txn_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      txn_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      txn_q <= txn_d;
    end
  end
  assign done_o = cnt_q == 3'd1;
  assign txn_o  = txn_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, data first with a fetch starvation guard.
// MEM_ARB_MISALIGN_CHK_EN: misaligned requests skip the memory and complete with rdata 0 and err_misalign_o.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_MISALIGN_CHK_EN
  , output logic err_misalign_o
`endif
);
  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] if_hold_q, if_hold_d, d_hold_q, d_hold_d;
  logic              any_req, sel_if, grant, mis, done;
  logic [ADDR_W-1:0] addr;
  txn_t              txn_new, txn_done;

  mem_arb_lat_tracker #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk(clk), .rst_n(rst_n), .load_i(grant), .txn_i(txn_new), .done_o(done), .txn_o(txn_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      if_hold_q <= '0;
      d_hold_q  <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      if_hold_q <= if_hold_d;
      d_hold_q  <= d_hold_d;
    end
  end

  always_comb begin
    state_d   = ((state_q == IDLE) | done) ? (grant ? WAIT : IDLE) : state_q;
    starve_d  = bus.if_gnt ? '0 :
                bus.d_gnt  ? (bus.if_req ? (starve_q == 4'(STARVE_MAX) ? starve_q : starve_q + 4'd1) : '0) :
                starve_q;
    if_hold_d = bus.if_rvalid ? bus.if_rdata : if_hold_q;
    d_hold_d  = bus.d_rvalid ? bus.d_rdata : d_hold_q;
  end

  // A new grant may issue in the same cycle the previous access completes.
  always_comb begin
    any_req       = bus.if_req | bus.d_req;
    sel_if        = bus.if_req & (~bus.d_req | (starve_q == 4'(STARVE_MAX)));
    grant         = rst_n & any_req & ((state_q == IDLE) | done);
    addr          = sel_if ? bus.if_addr : bus.d_addr;
`ifdef MEM_ARB_MISALIGN_CHK_EN
    mis           = |addr[1:0];
`else
    mis           = 1'b0;
`endif
    txn_new       = '{id: sel_if ? REQ_IF : REQ_D, we: ~sel_if & bus.d_we, mis: mis};
    bus.if_gnt    = grant & sel_if;
    bus.d_gnt     = grant & ~sel_if;
    bus.mem_en    = grant & ~mis;
    bus.mem_we    = bus.mem_en & ~sel_if & bus.d_we;
    bus.mem_addr  = bus.mem_en ? ADDR_W'(byte_to_word(ADDR_W_DEF'(addr))) : '0;
    bus.mem_wdata = (bus.mem_en & ~sel_if) ? bus.d_wdata : '0;
    bus.if_rvalid = done & (txn_done.id == REQ_IF);
    bus.d_rvalid  = done & (txn_done.id == REQ_D);
    bus.if_rdata  = bus.if_rvalid ? (txn_done.mis ? '0 : bus.mem_rdata) : if_hold_q;
    bus.d_rdata   = bus.d_rvalid ? ((txn_done.we | txn_done.mis) ? '0 : bus.mem_rdata) : d_hold_q;
    bus.busy      = state_q == WAIT;
  end

`ifdef MEM_ARB_MISALIGN_CHK_EN
  assign err_misalign_o = done & txn_done.mis;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int LAT = 3, SMAX = 4, AW = 32, DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef MEM_ARB_MISALIGN_CHK_EN
  logic err_mis;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef MEM_ARB_MISALIGN_CHK_EN
    , .err_misalign_o(err_mis)
`endif
  );

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Memory environment: fixed-latency pipe, junk on idle cycles
  logic [DW-1:0] mem [16];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] dl [LAT];
  assign bus.mem_rdata = dl[LAT-1];
  always @(posedge clk) begin
    dl[0] <= bus.mem_en ? mem[bus.mem_addr[3:0]] : DW'($urandom);
    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
  end

  typedef struct {
    bit            is_d;
    bit            mis;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sbq[$];

  // Reference model: one access in flight, next slot LAT cycles after issue
  int            free_at = -1, starve = 0, m_w;
  bit            m_sif, m_g, m_mis, m_we, rec = 0;
  logic [AW-1:0] m_a;
  exp_t          m_e;
  bit            gseq[$];
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      free_at = -1;
      starve  = 0;
      chk("rst_ctl", {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we, bus.busy}, 0);
      chk("rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
      chk("rst_mem", {bus.mem_addr, bus.mem_wdata}, 0);
    end else begin
      if (rec && (bus.if_gnt || bus.d_gnt)) gseq.push_back(bus.d_gnt);
      m_sif = bus.if_req && (!bus.d_req || starve == SMAX);
      m_g   = (bus.if_req || bus.d_req) && cyc >= free_at;
      m_a   = m_sif ? bus.if_addr : bus.d_addr;
`ifdef MEM_ARB_MISALIGN_CHK_EN
      m_mis = m_a[1:0] != 2'b00;
`else
      m_mis = 1'b0;
`endif
      m_we = !m_sif && bus.d_we;
      chk("if_gnt", bus.if_gnt, m_g && m_sif);
      chk("d_gnt", bus.d_gnt, m_g && !m_sif);
      chk("mem_en", bus.mem_en, m_g && !m_mis);
      chk("busy", bus.busy, cyc <= free_at);
      if (m_g && !m_mis) begin
        chk("mem_we", bus.mem_we, m_we);
        chk("mem_addr", bus.mem_addr, m_a / 4);
        chk("mem_wdata", bus.mem_wdata, m_sif ? '0 : bus.d_wdata);
      end
      if (m_g) begin
        m_w       = (m_a / 4) % 16;
        m_e.is_d  = !m_sif;
        m_e.mis   = m_mis;
        m_e.due   = cyc + LAT;
        m_e.data  = (m_we || m_mis) ? '0 : ref_mem[m_w];
        if (m_we && !m_mis) ref_mem[m_w] = bus.d_wdata;
        sbq.push_back(m_e);
        starve  = m_sif ? 0 : (bus.if_req ? (starve < SMAX ? starve + 1 : SMAX) : 0);
        free_at = cyc + LAT;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response appears
  exp_t          mon_e;
  logic [DW-1:0] last_if = '0, last_d = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_if = '0;
      last_d  = '0;
    end else begin
      if (bus.if_rvalid || bus.d_rvalid) begin
        chk("one_rvalid", bus.if_rvalid && bus.d_rvalid, 0);
        if (sbq.size() == 0) fail_now("rvalid_unexpected");
        else begin
          mon_e = sbq.pop_front();
          chk("rv_owner", bus.d_rvalid, mon_e.is_d);
          chk("rv_cycle", 64'(cyc), 64'(mon_e.due));
          chk("rdata", mon_e.is_d ? bus.d_rdata : bus.if_rdata, mon_e.data);
`ifdef MEM_ARB_MISALIGN_CHK_EN
          chk("err_misalign", err_mis, mon_e.mis);
`endif
        end
      end else begin
        if (sbq.size() != 0 && sbq[0].due <= cyc) begin
          fail_now("rvalid_missing");
          void'(sbq.pop_front());
        end
`ifdef MEM_ARB_MISALIGN_CHK_EN
        chk("err_idle", err_mis, 0);
`endif
      end
      if (bus.if_rvalid) last_if = bus.if_rdata;
      else chk("if_hold", bus.if_rdata, last_if);
      if (bus.d_rvalid) last_d = bus.d_rdata;
      else chk("d_hold", bus.d_rdata, last_d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit is_d);
    int n = 0;
    forever begin
      @(negedge clk);
      if (is_d ? bus.d_gnt : bus.if_gnt) break;
      if (++n > 40) begin
        fail_now("gnt_timeout");
        break;
      end
    end
    tick();
  endtask

  task automatic req_if(input logic [AW-1:0] a);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    wait_gnt(1'b0);
    bus.if_req  = 1'b0;
  endtask

  task automatic req_d(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    wait_gnt(1'b1);
    bus.d_req   = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] a = AW'($urandom_range(63, 0));
    if ($urandom_range(7, 0) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  bit exp_ord [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  bit gi, gd;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'hA5000000 + i * 32'h00010101;
      ref_mem[i] = 32'hA5000000 + i * 32'h00010101;
    end
    for (int i = 0; i < LAT; i++) dl[i] = '0;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    req_if(32'h10);
    repeat (LAT + 1) tick();
    req_d(1'b1, 32'h20, 32'hDEADBEEF);
    req_d(1'b0, 32'h20, '0);
    repeat (LAT + 1) tick();
`ifdef MEM_ARB_MISALIGN_CHK_EN
    req_d(1'b0, 32'h22, '0);
    repeat (LAT + 1) tick();
`endif
    // Contention with both requests held continuously
    rec = 1;
    bus.if_req = 1; bus.if_addr = 32'h4; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h8;
    repeat (10 * LAT + 2) tick();
    bus.if_req = 0; bus.d_req = 0; rec = 0;
    repeat (LAT + 1) tick();
    chk("contention_count", 64'(gseq.size() >= 10), 1);
    if (gseq.size() >= 10)
      for (int i = 0; i < 10; i++) chk($sformatf("order%0d", i), gseq[i], exp_ord[i]);
    // Back-to-back fetches
    bus.if_req = 1; bus.if_addr = 32'h18;
    repeat (4 * LAT) tick();
    bus.if_req = 0;
    repeat (LAT + 1) tick();
    // Reset in the middle of an outstanding load
    req_d(1'b0, 32'h24, '0);
    #1;
    rst_n = 1'b0;
    bus.if_req = 1; bus.if_addr = 32'h30;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_gnt_after_reset", bus.if_gnt, 1);
    tick();
    bus.if_req = 0;
    repeat (LAT + 1) tick();
    // Random traffic with occasional withdrawn requests
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      gi = bus.if_gnt;
      gd = bus.d_gnt;
      tick();
      if (bus.if_req && !gi) begin
        if ($urandom_range(15, 0) == 0) bus.if_req = 0;
      end else begin
        bus.if_req  = $urandom_range(1, 0) == 1;
        bus.if_addr = rnd_addr();
      end
      if (bus.d_req && !gd) begin
        if ($urandom_range(15, 0) == 0) bus.d_req = 0;
      end else begin
        bus.d_req   = $urandom_range(1, 0) == 1;
        bus.d_we    = $urandom_range(1, 0) == 1;
        bus.d_addr  = rnd_addr();
        bus.d_wdata = DW'($urandom);
      end
    end
    bus.if_req = 0; bus.d_req = 0;
    repeat (LAT + 2) tick();
    chk("sb_drained", 64'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
